// File: rtl/key_input.sv
// Per-channel key debouncer with press/release/long-press event pulses.
// Optional long-press detection is compiled in with `define KEY_LONG_PRESS_EN.
module key_input #(
  parameter int CLOCK_FREQ  = 27000000,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000,
  parameter int N_KEYS      = 2
) (
  input  logic              clk_27m,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  localparam logic [31:0] DB_TICKS   = 32'(CLOCK_FREQ / 1000 * DEBOUNCE_MS);
  localparam logic [31:0] LONG_TICKS = 32'(CLOCK_FREQ / 1000 * LONG_MS);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_t;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    logic [1:0]  sync;
    logic        pressed;
    state_t      state;
    logic [31:0] db_cnt;
    logic        level_r;
    logic        press_r;
    logic        release_r;

    // Synchronizer resets to the released level so reset never mimics a press.
    always_ff @(posedge clk_27m or negedge rst_n) begin
      if (!rst_n) sync <= '1;
      else        sync <= {sync[0], key_n[g]};
    end

    assign pressed = ~sync[1];

`ifdef KEY_LONG_PRESS_EN
    logic [31:0] hold_cnt;
    logic        long_fired;
    logic        long_r;

    always_ff @(posedge clk_27m or negedge rst_n) begin
      if (!rst_n) begin
        hold_cnt   <= '0;
        long_fired <= 1'b0;
        long_r     <= 1'b0;
      end else begin
        long_r <= 1'b0;
        case (state)
          PRESS_DB: begin
            if (pressed && db_cnt == DB_TICKS - 32'd1) begin
              hold_cnt   <= '0;
              long_fired <= 1'b0;
            end
          end
          HELD: begin
            if (pressed && hold_cnt != LONG_TICKS - 32'd1)
              hold_cnt <= hold_cnt + 32'd1;
            if (hold_cnt == LONG_TICKS - 32'd1 && !long_fired) begin
              long_r     <= 1'b1;
              long_fired <= 1'b1;
            end
          end
          RELEASE_DB: begin
            if (!pressed && db_cnt == DB_TICKS - 32'd1)
              long_fired <= 1'b0;
          end
          default: ;
        endcase
      end
    end

    assign key_long[g] = long_r;
`else
    assign key_long[g] = 1'b0;
`endif

    always_ff @(posedge clk_27m or negedge rst_n) begin
      if (!rst_n) begin
        state     <= IDLE;
        db_cnt    <= '0;
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
        case (state)
          IDLE: begin
            if (pressed) begin
              state  <= PRESS_DB;
              db_cnt <= '0;
            end
          end
          PRESS_DB: begin
            if (!pressed) begin
              state <= IDLE;
            end else if (db_cnt == DB_TICKS - 32'd1) begin
              state   <= HELD;
              level_r <= 1'b1;
              press_r <= 1'b1;
            end else begin
              db_cnt <= db_cnt + 32'd1;
            end
          end
          HELD: begin
            if (!pressed) begin
              state  <= RELEASE_DB;
              db_cnt <= '0;
            end
          end
          RELEASE_DB: begin
            if (pressed) begin
              state <= HELD;
            end else if (db_cnt == DB_TICKS - 32'd1) begin
              state     <= IDLE;
              level_r   <= 1'b0;
              release_r <= 1'b1;
            end else begin
              db_cnt <= db_cnt + 32'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign key_level[g]   = level_r;
    assign key_press[g]   = press_r;
    assign key_release[g] = release_r;
  end

endmodule

// File: doc/key_input.md
KEY_INPUT -- requirements
Module: key_input

Interface
- REQ-001 SHALL have parameter CLOCK_FREQ, default 27000000, meaning clk_27m frequency in Hz.
- REQ-002 SHALL have parameter DEBOUNCE_MS, default 10, meaning the stable-level time (in ms) needed to accept a press or release; legal range is 1 or more.
- REQ-003 SHALL have parameter LONG_MS, default 1000, meaning the hold time (in ms) before a long-press event; must be greater than DEBOUNCE_MS.
- REQ-004 SHALL have parameter N_KEYS, default 2, meaning the number of independent key channels.
- REQ-005 SHALL have port clk_27m, input, 1 bit: the single system clock; all logic runs on its rising edge.
- REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-007 SHALL have port key_n, input, N_KEYS bits: raw onboard buttons, asynchronous, active low (0 = pressed).
- REQ-008 SHALL have port key_level, output, N_KEYS bits: debounced pressed state (1 = pressed).
- REQ-009 SHALL have port key_press, output, N_KEYS bits: one-cycle pulse when a press is accepted.
- REQ-010 SHALL have port key_release, output, N_KEYS bits: one-cycle pulse when a release is accepted.
- REQ-011 SHALL have port key_long, output, N_KEYS bits: one-cycle pulse when a press has been held for LONG_MS.

Function
- REQ-012 SHALL derive DB_TICKS = CLOCK_FREQ/1000*DEBOUNCE_MS and LONG_TICKS = CLOCK_FREQ/1000*LONG_MS, using 32-bit counters.
- REQ-013 SHALL pass each key_n bit through a 2-flop synchronizer; pressed = inverted synchronizer output.
- REQ-014 SHALL give each channel its own FSM, db_cnt, hold_cnt and long_fired flag, with no interaction between channels.
- REQ-015 SHALL implement these FSM states and transitions:
  - IDLE -> PRESS_DB when pressed; db_cnt is cleared.
  - PRESS_DB -> IDLE when not pressed (bounce rejected, no output).
  - Otherwise in PRESS_DB, db_cnt increments each cycle.
- REQ-016 SHALL, in PRESS_DB, take the transition to HELD on the cycle db_cnt == DB_TICKS-1 while pressed, and at that point:
  - set key_level = 1;
  - pulse key_press for one cycle;
  - clear hold_cnt and long_fired.
- REQ-017 SHALL, in HELD, increment hold_cnt each cycle, saturating at LONG_TICKS-1.
- REQ-018 SHALL pulse key_long for one cycle, and set long_fired, on the first cycle in HELD with hold_cnt == LONG_TICKS-1 and long_fired == 0. This fires at most once per accepted press.
- REQ-019 SHALL go from HELD to RELEASE_DB when not pressed, clearing db_cnt; hold_cnt keeps its value but does not advance in RELEASE_DB.
- REQ-020 SHALL handle RELEASE_DB as follows:
  - pressed -> HELD (release bounce rejected); key_level stays 1 and hold_cnt resumes.
  - Not pressed -> db_cnt increments.
  - At db_cnt == DB_TICKS-1 -> IDLE, with key_level = 0, a one-cycle key_release pulse, and long_fired cleared.
- REQ-021 SHALL assert key_press DB_TICKS+2 cycles after the first clk_27m edge that samples key_n low, given a clean input.
- REQ-022 SHALL assert key_release DB_TICKS+2 cycles after the first edge that samples key_n high, given a clean input.
- REQ-023 SHALL never assert key_press and key_release of the same channel in the same cycle.
- REQ-024 SHALL allow key_long and key_release to occur only in different cycles.
- REQ-025 SHALL drive registered outputs; pulses are exactly 1 cycle wide.

Reset
- REQ-026 SHALL, while rst_n = 0, asynchronously force all FSMs to IDLE and clear all counters, synchronizers and long_fired.
- REQ-027 SHALL drive key_level, key_press, key_release and key_long to 0 during reset.
- REQ-028 SHALL, on reset during PRESS_DB, HELD or RELEASE_DB, abort the event with no pulse on deassertion.
- REQ-029 SHALL, if a key is still held after reset deasserts, re-debounce it from IDLE as a new press.

Configuration
- REQ-030 SHALL use macro KEY_LONG_PRESS_EN:
  - Defined: hold_cnt, long_fired and the key_long logic are compiled in as in REQ-017/018.
  - Undefined: that logic is removed, key_long is tied to 0, and all other behaviour is unchanged.

Verification (CLOCK_FREQ=1000, DEBOUNCE_MS=4, LONG_MS=20, so DB_TICKS=4 and LONG_TICKS=20; KEY_LONG_PRESS_EN defined unless noted)
- REQ-031 SHALL cover a clean press: key_n[0] low at cycle 10 and held -> key_press[0] pulse at cycle 16, key_level[0] = 1 from cycle 16.
- REQ-032 SHALL cover press bounce: key_n[0] low 3 cycles, high 1, then low steady -> no pulse during the bounce; key_press[0] 6 cycles after the final falling sample.
- REQ-033 SHALL cover a long press: hold key_n[0] low for 40 cycles -> one key_long[0] pulse 20 cycles after key_press[0]; then release -> key_release[0] 6 cycles later with no second key_long.
- REQ-034 SHALL cover release bounce: while held, key_n[0] high for 2 cycles then low -> no key_release[0], and key_level[0] stays 1.
- REQ-035 SHALL cover reset mid-hold: assert rst_n = 0 during HELD -> all outputs 0 immediately; after release of reset with the key still low -> a new key_press[0] after 6 cycles.
- REQ-036 SHALL cover independence and the macro-off build:
  - Press key 1 while key 0 is held -> pulses occur only on channel 1.
  - With KEY_LONG_PRESS_EN undefined, a 40-cycle hold leaves key_long at 0.
